// File: rtl/sample_player_if.sv
// Control, sample-memory and status signals of the sample player.
// The DUT uses the slave modport and the controller/memory side uses master.
interface sample_player_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 10,
    parameter int unsigned DIV_W  = 16
);
    logic              start;
    logic              stop;
    logic              loop_en;
    logic [DIV_W-1:0]  rate_div;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] sample_out;
    logic              sample_valid;
    logic              busy;
    logic              done;

    modport master (
        output start, stop, loop_en, rate_div, mem_data,
        input  mem_addr, sample_out, sample_valid, busy, done
    );

    modport slave (
        input  start, stop, loop_en, rate_div, mem_data,
        output mem_addr, sample_out, sample_valid, busy, done
    );
endinterface

// File: rtl/sample_player.sv
// Plays NUM_SAMPLES entries from a synchronous sample memory.
// One sample is emitted every max(rate_div,2)+1 clocks, either one-shot or looping.
module sample_player #(
    parameter int unsigned NUM_SAMPLES = 218,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 10,
    parameter int unsigned DIV_W       = 16
) (
    input logic            clk,
    input logic            rst_n,
    sample_player_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StFetch, StCapture, StWait} state_e;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_SAMPLES - 1);
    localparam logic [DIV_W-1:0]  MinDiv   = DIV_W'(2);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d, cnt_load;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;

    // Counter reloads with period-1 so the next FETCH lands exactly one period later.
    assign cnt_load = (bus.rate_div < MinDiv) ? MinDiv : bus.rate_div;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        done_d   = 1'b0;

        if (state_q != StIdle) begin
            cnt_d = cnt_q - DIV_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (bus.start && !bus.stop) begin
                    state_d = StFetch;
                    addr_d  = '0;
                    cnt_d   = cnt_load;
                end
            end
            StFetch: state_d = StCapture;
            StCapture: begin
                state_d  = StWait;
                sample_d = bus.mem_data;
                valid_d  = 1'b1;
            end
            StWait: begin
                if (cnt_q == '0) begin
                    if (addr_q < LastAddr) begin
                        state_d = StFetch;
                        addr_d  = addr_q + ADDR_W'(1);
                        cnt_d   = cnt_load;
                    end else if (bus.loop_en) begin
                        state_d = StFetch;
                        addr_d  = '0;
                        cnt_d   = cnt_load;
                    end else begin
                        state_d = StIdle;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort overrides every other transition and discards a pending capture.
        if (state_q != StIdle && bus.stop) begin
            state_d  = StIdle;
            addr_d   = addr_q;
            cnt_d    = '0;
            sample_d = sample_q;
            valid_d  = 1'b0;
            done_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            cnt_q    <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    assign bus.mem_addr     = addr_q;
    assign bus.sample_out   = sample_q;
    assign bus.sample_valid = valid_q;
    assign bus.done         = done_q;
    assign bus.busy         = (state_q != StIdle);
endmodule

// File: doc/sample_player.md
SAMPLE_PLAYER -- requirements
Module: sample_player

Interface
REQ-001 SHALL have parameter NUM_SAMPLES, default 218: number of sample-memory entries played (addresses 0..NUM_SAMPLES-1).
REQ-002 SHALL have parameter ADDR_W, default 8: sample-memory address width; must hold NUM_SAMPLES-1.
REQ-003 SHALL have parameter DATA_W, default 10: sample width.
REQ-004 SHALL have parameter DIV_W, default 16: width of rate_div.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock for all state.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  one-cycle request to begin playback from address 0.
REQ-008 stop  in  1  one-cycle request to abort playback.
REQ-009 loop_en  in  1  1 = wrap to address 0 after the last sample; 0 = one-shot.
REQ-010 rate_div  in  DIV_W  sample period in clocks minus 1.
REQ-011 mem_addr  out  ADDR_W  registered read address to the synchronous sample memory (1-cycle read latency).
REQ-012 mem_data  in  DATA_W  read data from the sample memory.
REQ-013 sample_out  out  DATA_W  current held sample.
REQ-014 sample_valid  out  1  one-cycle pulse when sample_out updates.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle pulse when one-shot playback completes.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, CAPTURE, WAIT; every non-IDLE state lasts at least one cycle.
REQ-018 IDLE: start=1 and stop=0 -> FETCH, mem_addr<=0, period latched; otherwise remain IDLE.
REQ-019 Period P SHALL be max(rate_div,2)+1 clocks; rate_div is latched only on each entry into FETCH; changes mid-sample take effect on the next sample.
REQ-020 Down-counter SHALL load P-1 on entry into FETCH and decrement by 1 each cycle in FETCH, CAPTURE and WAIT.
REQ-021 FETCH -> CAPTURE unconditionally (memory latches mem_addr this cycle).
REQ-022 CAPTURE -> WAIT; on that edge sample_out<=mem_data and sample_valid<=1 for exactly one cycle.
REQ-023 WAIT with counter != 0: stay in WAIT.
REQ-024 WAIT with counter == 0 and mem_addr < NUM_SAMPLES-1: mem_addr<=mem_addr+1, -> FETCH.
REQ-025 WAIT with counter == 0 and mem_addr == NUM_SAMPLES-1: loop_en=1 -> mem_addr<=0, -> FETCH; loop_en=0 -> IDLE, done<=1 for one cycle; loop_en is sampled only at this decision.
REQ-026 Consecutive sample_valid pulses SHALL be exactly P cycles apart, including across the wrap.
REQ-027 First sample_valid SHALL assert 2 cycles after the edge that samples start.
REQ-028 mem_addr SHALL never exceed NUM_SAMPLES-1.
REQ-029 stop=1 in any non-IDLE state -> IDLE on the next edge; no done pulse; sample_out holds; a pending CAPTURE is discarded (no sample_valid).
REQ-030 stop and start both high in IDLE: stop wins, remain IDLE.
REQ-031 start while busy SHALL be ignored (no restart).
REQ-032 In IDLE, mem_addr and sample_out SHALL hold their last values.

Reset
REQ-033 rst_n=0 SHALL immediately force state=IDLE, mem_addr=0, sample_out=0, sample_valid=0, done=0, busy=0, counter=0, irrespective of clk.
REQ-034 Reset asserted mid-playback SHALL abort with no done pulse; after release the block stays IDLE until a new start.

Verification
REQ-035 Memory preloaded with data=address; start, loop_en=0, rate_div=4 -> 218 sample_valid pulses 5 cycles apart, values 0..217, done once 5 cycles after the last FETCH entry, busy low afterwards.
REQ-036 loop_en=1, rate_div=2 -> after value 217, next sample is 0 exactly 3 cycles later; no done pulse.
REQ-037 rate_div=0 and rate_div=1 -> pulse spacing 3 cycles (clamped).
REQ-038 stop pulsed in CAPTURE of sample 10 -> no sample_valid for sample 10, IDLE next edge, sample_out=9, done stays 0.
REQ-039 rst_n pulled low between clock edges during WAIT -> all outputs 0 at once; start issued after release -> first sample_valid 2 cycles later with value 0.
REQ-040 start pulsed again at sample 50, and start+stop together in IDLE -> playback unaffected by the first; block stays IDLE for the second.
